bounding_box_accumulator: RTL and testbench
===========================================

BOUNDING_BOX_ACCUMULATOR -- requirements
Module: bounding_box_accumulator

Interface
REQ-001 SHALL have parameter COUNT_W, default 16, width of the per-cluster point counter.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, point present on in_x/in_y/in_z.
REQ-005 SHALL have port in_ready, output, 1, block accepts a point this cycle.
REQ-006 SHALL have ports in_x, in_y, in_z, input, 32 each, signed Q16.16 point coordinates.
REQ-007 SHALL have port in_last, input, 1, final point of the current cluster.
REQ-008 SHALL have ports min_x, min_y, min_z, output, 32 each, signed Q16.16 cluster minima.
REQ-009 SHALL have ports max_x, max_y, max_z, output, 32 each, signed Q16.16 cluster maxima.
REQ-010 SHALL have port point_count, output, COUNT_W, number of points in the reported cluster.
REQ-011 SHALL have port out_valid, output, 1, min/max/count valid for one cluster.
REQ-012 SHALL have port out_ready, input, 1, downstream (dimension stage) accepts result.

Function
REQ-013 SHALL transfer a point only when in_valid and in_ready are both 1 on a rising clk edge.
REQ-014 SHALL transfer a result only when out_valid and out_ready are both 1 on a rising clk edge.
REQ-015 SHALL implement states IDLE, ACCUM, DONE.
REQ-016 IDLE: in_ready=1, out_valid=0; an accepted point loads min_*=max_*=that point and point_count=1.
REQ-017 IDLE transition: an accepted point with in_last=0 goes to ACCUM; with in_last=1 goes to DONE.
REQ-018 ACCUM: in_ready=1, out_valid=0; for each accepted point, each axis min updates when in < min and each axis max updates when in > max.
REQ-019 ACCUM: point_count increments per accepted point and saturates at 2^COUNT_W-1; min/max updates continue after saturation.
REQ-020 ACCUM transition: an accepted point with in_last=1 is included in min/max/count and moves the block to DONE.
REQ-021 DONE: in_ready=0, out_valid=1; min_*, max_*, and point_count are held stable until the result transfers.
REQ-022 DONE transition: a result transfer moves the block to IDLE; out_valid=0 and in_ready=1 in the following cycle.
REQ-023 All comparisons SHALL be signed two's-complement on the full 32 bits; no arithmetic is performed on coordinates.
REQ-024 Latency: out_valid SHALL rise on the edge that accepts the in_last point, i.e. the cycle immediately after the transfer.
REQ-025 in_ready and out_valid SHALL be functions of state only, with no combinational path from in_valid or out_ready.
REQ-026 Invariant: min_* <= max_* per axis whenever out_valid=1.
REQ-027 A single-point cluster (in_last on the first point) SHALL report min=max=that point and point_count=1.
REQ-028 in_* values while in_ready=0 or in_valid=0 SHALL be ignored.

Reset
REQ-029 Asserting rst SHALL immediately force state IDLE, in_ready=1, out_valid=0, all min_*/max_*=0, and point_count=0.
REQ-030 rst asserted mid-cluster or while in DONE SHALL discard the partial or pending result; no result is emitted for that cluster.
REQ-031 After rst deasserts, the first accepted point SHALL start a new cluster per REQ-016.

Verification
REQ-032 Three points (1.0,-2.0,3.0), (-4.0,5.0,0.5), (2.0,0.0,-1.0), last on the third -> min=(-4.0,-2.0,-1.0), max=(2.0,5.0,3.0), count=3, out_valid one cycle after the third point.
REQ-033 Single point (0x80000000,0x7FFFFFFF,0) with in_last=1 -> min=max=that point, count=1; checks signed extremes.
REQ-034 Result pending with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 throughout, outputs stable; then out_ready=1 -> IDLE next cycle and the next point starts a new cluster.
REQ-035 COUNT_W=4, 20-point cluster -> point_count=15 (saturated), min/max correct over all 20 points.
REQ-036 rst pulsed after 2 of 4 points, then a new 2-point cluster (1,1,1),(2,2,2) -> outputs cleared to 0 on reset; result min=(1,1,1), max=(2,2,2), count=2.
REQ-037 Back-to-back clusters with out_ready tied 1 and in_valid tied 1 -> exactly one in_ready=0 cycle between clusters; no point lost or double-counted.

Source files
------------

// File: rtl/bounding_box_accumulator.sv
// Per-axis signed min/max and saturating point count over a cluster ending at in_last.
// Result is valid the cycle after the in_last point is accepted; intake stalls until the result is taken.
module bounding_box_accumulator #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_x,
    input  logic [31:0]        in_y,
    input  logic [31:0]        in_z,
    input  logic               in_last,
    output logic [31:0]        min_x,
    output logic [31:0]        min_y,
    output logic [31:0]        min_z,
    output logic [31:0]        max_x,
    output logic [31:0]        max_y,
    output logic [31:0]        max_z,
    output logic [COUNT_W-1:0] point_count,
    output logic               out_valid,
    input  logic               out_ready
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t state;
    logic   take_pt;
    logic   give_res;

    assign take_pt  = in_valid && in_ready;
    assign give_res = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            min_x       <= '0;
            min_y       <= '0;
            min_z       <= '0;
            max_x       <= '0;
            max_y       <= '0;
            max_z       <= '0;
            point_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_pt) begin
                        min_x       <= in_x;
                        min_y       <= in_y;
                        min_z       <= in_z;
                        max_x       <= in_x;
                        max_y       <= in_y;
                        max_z       <= in_z;
                        point_count <= COUNT_W'(1);
                        if (in_last) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (take_pt) begin
                        if ($signed(in_x) < $signed(min_x)) min_x <= in_x;
                        if ($signed(in_y) < $signed(min_y)) min_y <= in_y;
                        if ($signed(in_z) < $signed(min_z)) min_z <= in_z;
                        if ($signed(in_x) > $signed(max_x)) max_x <= in_x;
                        if ($signed(in_y) > $signed(max_y)) max_y <= in_y;
                        if ($signed(in_z) > $signed(max_z)) max_z <= in_z;
                        // Count pins at all-ones; extents keep tracking every point.
                        if (point_count != {COUNT_W{1'b1}}) begin
                            point_count <= point_count + COUNT_W'(1);
                        end
                        if (in_last) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (give_res) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bounding_box_accumulator.sv
// Randomized scoreboard bench for bounding_box_accumulator with a queue-based cluster model.
module tb_bounding_box_accumulator;

    localparam int CW = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_x, in_y, in_z;
    logic          in_last;
    logic [31:0]   min_x, min_y, min_z, max_x, max_y, max_z;
    logic [CW-1:0] point_count;
    logic          out_valid;
    logic          out_ready;

    bounding_box_accumulator #(.COUNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_last(in_last),
        .min_x(min_x), .min_y(min_y), .min_z(min_z),
        .max_x(max_x), .max_y(max_y), .max_z(max_z),
        .point_count(point_count),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]   mnx, mny, mnz, mxx, mxy, mxz;
        logic [CW-1:0] cnt;
    } res_t;

    res_t        exp_q[$];
    logic [31:0] px[$], py[$], pz[$];
    int          checks = 0;
    int          errors = 0;
    int          or_mode = 0;
    bit          exp_ov_next = 0;
    bit          exp_idle_next = 0;
    bit          hold_chk = 0;
    res_t        held;

    task automatic check(string name, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic res_t dut_res();
        res_t r;
        r = '{min_x, min_y, min_z, max_x, max_y, max_z, point_count};
        return r;
    endfunction

    // Reference: extents over the whole list of accepted points, count clipped.
    function automatic res_t model();
        res_t r;
        int signed mn[3], mx[3], v[3];
        for (int i = 0; i < px.size(); i++) begin
            v[0] = $signed(px[i]); v[1] = $signed(py[i]); v[2] = $signed(pz[i]);
            for (int a = 0; a < 3; a++) begin
                if (i == 0 || v[a] < mn[a]) mn[a] = v[a];
                if (i == 0 || v[a] > mx[a]) mx[a] = v[a];
            end
        end
        r.mnx = mn[0]; r.mny = mn[1]; r.mnz = mn[2];
        r.mxx = mx[0]; r.mxy = mx[1]; r.mxz = mx[2];
        r.cnt = CW'((px.size() > MAXC) ? MAXC : px.size());
        return r;
    endfunction

    // Monitor: samples on the falling edge, between the edges where transfers happen.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete(); px.delete(); py.delete(); pz.delete();
                exp_ov_next = 0; exp_idle_next = 0; hold_chk = 0;
                continue;
            end
            if (exp_ov_next) begin
                check("latency_out_valid", 256'(out_valid), 256'(1));
                exp_ov_next = 0;
            end
            if (exp_idle_next) begin
                check("idle_after_xfer", 256'({in_ready, out_valid}), 256'(2'b10));
                exp_idle_next = 0;
            end
            if (hold_chk) begin
                check("hold_stable", 256'(dut_res()), 256'(held));
                hold_chk = 0;
            end
            if (out_valid) begin
                check("in_ready_low_in_done", 256'(in_ready), 256'(0));
                check("min_le_max", 256'({$signed(min_x) <= $signed(max_x),
                                          $signed(min_y) <= $signed(max_y),
                                          $signed(min_z) <= $signed(max_z)}), 256'(3'b111));
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 256'(1), 256'(0));
                    end else begin
                        res_t e;
                        e = exp_q.pop_front();
                        check("min_x", 256'(min_x), 256'(e.mnx));
                        check("min_y", 256'(min_y), 256'(e.mny));
                        check("min_z", 256'(min_z), 256'(e.mnz));
                        check("max_x", 256'(max_x), 256'(e.mxx));
                        check("max_y", 256'(max_y), 256'(e.mxy));
                        check("max_z", 256'(max_z), 256'(e.mxz));
                        check("point_count", 256'(point_count), 256'(e.cnt));
                    end
                    exp_idle_next = 1;
                end else begin
                    held = dut_res();
                    hold_chk = 1;
                end
            end
            if (in_valid && in_ready) begin
                px.push_back(in_x); py.push_back(in_y); pz.push_back(in_z);
                if (in_last) begin
                    exp_q.push_back(model());
                    px.delete(); py.delete(); pz.delete();
                    exp_ov_next = 1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    function automatic logic [31:0] rnd_coord();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'($signed($urandom_range(0, 64)) - 32) <<< 16;
            default: return $urandom;
        endcase
    endfunction

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            in_x = $urandom; in_y = $urandom; in_z = $urandom; in_last = $urandom_range(0, 1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(logic [31:0] x, logic [31:0] y, logic [31:0] z, logic last);
        int t;
        in_valid = 1'b1; in_x = x; in_y = y; in_z = z; in_last = last;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 200) begin
                check("send_timeout", 256'(1), 256'(0));
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_cluster(int n, bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send(rnd_coord(), rnd_coord(), rnd_coord(), i == n - 1);
        end
    endtask

    task automatic wait_drain();
        int t;
        idle(1);
        t = 0;
        while (exp_q.size() != 0 || out_valid) begin
            @(posedge clk);
            #1;
            t++;
            if (t > 500) begin
                check("drain_timeout", 256'(1), 256'(0));
                break;
            end
        end
        idle(1);
    endtask

    task automatic check_reset_state(string name);
        check({name, "_hs"}, 256'({in_ready, out_valid}), 256'(2'b10));
        check({name, "_data"}, 256'(dut_res()), 256'(0));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_z = '0; in_last = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset_state("reset_state");
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Three-point mixed-sign cluster.
        send(32'h0001_0000, 32'hFFFE_0000, 32'h0003_0000, 1'b0);
        send(32'hFFFC_0000, 32'h0005_0000, 32'h0000_8000, 1'b0);
        send(32'h0002_0000, 32'h0000_0000, 32'hFFFF_0000, 1'b1);
        wait_drain();

        // Single point at the signed extremes.
        send(32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1);
        wait_drain();

        // Result held off for several cycles while a point waits at the input.
        or_mode = 2;
        send(32'h0000_1234, 32'hFFFF_8000, 32'h0007_0000, 1'b1);
        in_valid = 1'b1; in_x = 32'h0003_0000; in_y = 32'h0004_0000; in_z = 32'hFFF0_0000; in_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
        end
        or_mode = 0;
        send(32'h0003_0000, 32'h0004_0000, 32'hFFF0_0000, 1'b0);
        send(32'h0001_0000, 32'h0009_0000, 32'h0000_0001, 1'b1);
        wait_drain();

        // Long cluster past the counter ceiling.
        send_cluster(20, 1'b0);
        wait_drain();

        // Reset mid-cluster, then a fresh two-point cluster.
        send(32'h0010_0000, 32'h0020_0000, 32'h0030_0000, 1'b0);
        send(32'hFFF0_0000, 32'h0005_0000, 32'h0006_0000, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_state("reset_mid_cluster");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 1'b0);
        send(32'h0002_0000, 32'h0002_0000, 32'h0002_0000, 1'b1);
        wait_drain();

        // Reset while a result is pending: it must be dropped.
        or_mode = 2;
        send(32'h0055_0000, 32'h0066_0000, 32'h0077_0000, 1'b1);
        idle(2);
        rst = 1'b1;
        #1;
        check_reset_state("reset_in_done");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        or_mode = 0;
        idle(3);
        check("no_result_after_reset", 256'(out_valid), 256'(0));

        // Back-to-back clusters with input valid and output ready held high.
        for (int c = 0; c < 10; c++) send_cluster($urandom_range(1, 6), 1'b0);
        wait_drain();

        // Random gaps and random downstream backpressure.
        or_mode = 1;
        for (int c = 0; c < 30; c++) send_cluster($urandom_range(1, 20), 1'b1);
        wait_drain();
        or_mode = 0;
        idle(2);
        check("scoreboard_empty", 256'(exp_q.size()), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
